v_logical_unshifter_seq: RTL and testbench
==========================================

// Module: v_logical_unshifter_seq
// PURPOSE
//  Sequential logical right shifter that undoes the left-shift stage in the datapath.
//  - Accepts a word plus a shift code over a valid/ready handshake.
//  - Shifts the word right by the clamped amount, one bit per clock.
//  - Returns the result with a flag that is set when any 1 bits were shifted out.
//  - Sits downstream of the left shifter; the flag shows whether SO is an exact inverse.
// PARAMETERS
//  WIDTH      8  data width of DI/SO
//  SELW       2  width of SEL
//  MAX_SHIFT  2  SEL codes >= MAX_SHIFT shift by MAX_SHIFT (saturating, like the forward decode)
// PORTS
//  CLK     in   1          single clock, rising edge
//  RST     in   1          synchronous, active-high reset
//  DI      in   WIDTH      input word
//  SEL     in   SELW       shift code; amount = (SEL < MAX_SHIFT) ? SEL : MAX_SHIFT
//  DI_VLD  in   1          input valid
//  DI_RDY  out  1          input ready (high only in IDLE)
//  SO      out  WIDTH      result word, registered
//  SO_LOST out  1          OR of every bit shifted out of SO[0] for this word
//  SO_VLD  out  1          result valid
//  SO_RDY  in   1          downstream ready
// BEHAVIOUR
//  - Reset (RST=1 at a rising edge): state=IDLE, SO=0, SO_LOST=0, SO_VLD=0, DI_RDY=1, count=0.
//    Reset overrides all other activity. An in-flight word is dropped; no partial result appears.
//  - FSM states: IDLE, SHIFT, DONE.
//    DI_RDY = (state==IDLE). SO_VLD = (state==DONE). Both are registered state decodes.
//  - IDLE, DI_VLD=1:
//    - Accept. SO<=DI, SO_LOST<=0, count<=clamped amount.
//    - Go to SHIFT if amount>0, otherwise go to DONE.
//  - SHIFT, each cycle:
//    - SO<=SO>>1 (zero fill at the MSB). SO_LOST<=SO_LOST|SO[0]. count<=count-1.
//    - If count==1, go to DONE.
//  - DONE:
//    - Hold SO, SO_LOST and SO_VLD stable until SO_RDY=1. On SO_VLD&&SO_RDY, go to IDLE.
//    - No bypass: a new word is accepted no earlier than the cycle after the output handshake.
//  - Latency: SO_VLD rises N+1 cycles after the accept edge, where N = clamped amount (0..MAX_SHIFT).
//  - Boundaries:
//    - DI_VLD outside IDLE is ignored, and DI/SEL are not sampled.
//    - SO_RDY is ignored outside DONE.
//    - SEL all-ones clamps to MAX_SHIFT.
//    - MAX_SHIFT must be <= WIDTH-1. Elaboration fails if it is not.
//  - Width rules:
//    - count is clog2(MAX_SHIFT+1) bits.
//    - The amount compare is done at SELW width before truncation into count.
// STRUCTURE
//  - Shared package logical_shift_pkg holds:
//    - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
//    - default MAX_SHIFT;
//    - clamp function amt_clamp(sel).
//    The forward shifter and its benches reuse the same package.
//  - Flat block: one FSM, one shift register, one down-counter. No sub-module is warranted.
// TESTING (WIDTH=8, SELW=2, MAX_SHIFT=2; cycles counted from the accept edge)
//  1. DI=8'hB4, SEL=2'b01, SO_RDY=1 -> SO=8'h5A, SO_LOST=0, SO_VLD at cycle 2 for exactly 1 cycle.
//  2. DI=8'hB5, SEL=2'b10 -> SO=8'h2D, SO_LOST=1, SO_VLD at cycle 3.
//  3. DI=8'hFF, SEL=2'b11 (clamped) -> SO=8'h3F, SO_LOST=1, SO_VLD at cycle 3. Clamp matches the forward default.
//  4. DI=8'h81, SEL=2'b00 -> SO=8'h81, SO_LOST=0, SO_VLD at cycle 1.
//  5. Backpressure: SO_RDY=0 for 5 cycles in DONE, with DI_VLD=1 and DI=8'h0F ->
//     SO/SO_LOST/SO_VLD stay stable, DI_RDY=0, and 8'h0F is accepted only after the handshake.
//  6. RST=1 for one cycle while in SHIFT (case 2, mid-shift) -> next cycle SO=0, SO_VLD=0,
//     SO_LOST=0, DI_RDY=1. A following DI=8'h04, SEL=2'b10 yields SO=8'h01, SO_LOST=0.
//  Scoreboard: for random DI/SEL, check SO==DI>>amt and SO_LOST==|(DI & ((1<<amt)-1)).

Source files
------------

// File: rtl/logical_shift_pkg.sv
// Shared definitions for the forward and inverse sequential logical shifters:
// FSM state encodings, default shift limit and the saturating shift-code decode.
package logical_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_MAX_SHIFT = 2;

  // Codes at or above the limit saturate to the limit.
  function automatic int unsigned amt_clamp(input int unsigned sel,
                                            input int unsigned max_shift = DEF_MAX_SHIFT);
    return (sel < max_shift) ? sel : max_shift;
  endfunction

endpackage

// File: rtl/v_logical_unshifter_seq.sv
// Sequential logical right shifter (one bit per clock) that flags any 1 bits lost off the LSB.
// Latency: SO_VLD seen N+1 edges after accept (N = clamped amount); holds in DONE until SO_RDY.
module v_logical_unshifter_seq
  import logical_shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SELW      = 2,
  parameter int MAX_SHIFT = int'(DEF_MAX_SHIFT)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DI,
  input  logic [SELW-1:0]  SEL,
  input  logic             DI_VLD,
  output logic             DI_RDY,
  output logic [WIDTH-1:0] SO,
  output logic             SO_LOST,
  output logic             SO_VLD,
  input  logic             SO_RDY
);

  localparam int CW = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1;

  generate
    if (MAX_SHIFT > WIDTH - 1) begin : g_bad_max_shift
      $error("MAX_SHIFT must not exceed WIDTH-1");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_so;
  logic             r_lost;
  logic [CW-1:0]    r_cnt;
  logic             r_di_rdy;
  logic             r_so_vld;
  logic [CW-1:0]    w_amt;

  // Clamp is evaluated on the full-width code, then narrowed to the counter.
  assign w_amt = CW'(amt_clamp(32'(SEL), 32'(MAX_SHIFT)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_so     <= '0;
      r_lost   <= 1'b0;
      r_cnt    <= '0;
      r_di_rdy <= 1'b1;
      r_so_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (DI_VLD) begin
            r_so     <= DI;
            r_lost   <= 1'b0;
            r_cnt    <= w_amt;
            r_di_rdy <= 1'b0;
            if (w_amt != '0) begin
              r_state  <= ST_SHIFT;
              r_so_vld <= 1'b0;
            end else begin
              r_state  <= ST_DONE;
              r_so_vld <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_so   <= r_so >> 1;
          r_lost <= r_lost | r_so[0];
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state  <= ST_DONE;
            r_so_vld <= 1'b1;
          end
        end
        ST_DONE: begin
          if (SO_RDY) begin
            r_state  <= ST_IDLE;
            r_so_vld <= 1'b0;
            r_di_rdy <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_so_vld <= 1'b0;
          r_di_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign DI_RDY  = r_di_rdy;
  assign SO      = r_so;
  assign SO_LOST = r_lost;
  assign SO_VLD  = r_so_vld;

endmodule

// File: tb/tb_v_logical_unshifter_seq.sv
// Self-checking bench for v_logical_unshifter_seq: directed cases, backpressure,
// mid-shift reset and a randomized scoreboard against an arithmetic reference.
module tb_v_logical_unshifter_seq;

  localparam int WIDTH     = 8;
  localparam int SELW      = 2;
  localparam int MAX_SHIFT = 2;
  localparam int TMO       = 20;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] DI;
  logic [SELW-1:0]  SEL;
  logic             DI_VLD;
  logic             DI_RDY;
  logic [WIDTH-1:0] SO;
  logic             SO_LOST;
  logic             SO_VLD;
  logic             SO_RDY;

  int n_cmp = 0;
  int n_err = 0;

  v_logical_unshifter_seq #(.WIDTH(WIDTH), .SELW(SELW), .MAX_SHIFT(MAX_SHIFT)) dut (
    .CLK(CLK), .RST(RST), .DI(DI), .SEL(SEL), .DI_VLD(DI_VLD), .DI_RDY(DI_RDY),
    .SO(SO), .SO_LOST(SO_LOST), .SO_VLD(SO_VLD), .SO_RDY(SO_RDY)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain arithmetic from the shift rules.
  function automatic int ref_amt(input logic [SELW-1:0] s);
    int v;
    v = int'({1'b0, s});
    return (v < MAX_SHIFT) ? v : MAX_SHIFT;
  endfunction

  function automatic logic [WIDTH-1:0] ref_so(input logic [WIDTH-1:0] d, input logic [SELW-1:0] s);
    return d >> ref_amt(s);
  endfunction

  function automatic logic ref_lost(input logic [WIDTH-1:0] d, input logic [SELW-1:0] s);
    logic [WIDTH-1:0] mask;
    mask = WIDTH'((1 << ref_amt(s)) - 1);
    return |(d & mask);
  endfunction

  // Present a word and return just after the edge that accepts it.
  task automatic send(input logic [WIDTH-1:0] d, input logic [SELW-1:0] s, output bit ok);
    ok = 1'b0;
    @(negedge CLK);
    DI = d; SEL = s; DI_VLD = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      if (DI_RDY === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (ok) begin
      @(posedge CLK);
      #1 DI_VLD = 1'b0;
    end else begin
      DI_VLD = 1'b0;
    end
  endtask

  // Called just after the accept edge; reports the edge index at which SO_VLD is first seen.
  task automatic wait_vld(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge CLK);
      if (SO_VLD === 1'b1) begin
        cyc = k + 1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1; DI_VLD = 1'b0; DI = '0; SEL = '0; SO_RDY = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({SO, SO_LOST, SO_VLD, DI_RDY} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got SO=%h LOST=%b VLD=%b RDY=%b, need 00 0 0 1", SO, SO_LOST, SO_VLD, DI_RDY);
    end
    RST = 1'b0;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] dv [4] = '{8'hB4, 8'hB5, 8'hFF, 8'h81};
    logic [SELW-1:0]  sv [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [WIDTH-1:0] eso [4] = '{8'h5A, 8'h2D, 8'h3F, 8'h81};
    logic             elo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int               elat [4] = '{2, 3, 3, 1};
    int cyc;
    bit ok;
    SO_RDY = 1'b1;
    for (int t = 0; t < 4; t++) begin
      send(dv[t], sv[t], ok);
      if (!ok) begin
        n_cmp++; n_err++;
        $display("FAIL dir%0d_accept: DI_RDY never high, need accept", t);
        continue;
      end
      wait_vld(cyc, ok);
      n_cmp++;
      if (!ok || cyc != elat[t]) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d (seen=%b), need %0d", t, cyc, ok, elat[t]);
      end
      n_cmp++;
      if (SO !== eso[t] || SO_LOST !== elo[t]) begin
        n_err++;
        $display("FAIL dir%0d_result: got SO=%h LOST=%b, need SO=%h LOST=%b", t, SO, SO_LOST, eso[t], elo[t]);
      end
      @(negedge CLK);
      n_cmp++;
      if (SO_VLD !== 1'b0 || DI_RDY !== 1'b1) begin
        n_err++;
        $display("FAIL dir%0d_one_cycle: got VLD=%b RDY=%b, need 0 1", t, SO_VLD, DI_RDY);
      end
    end
    SO_RDY = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    SO_RDY = 1'b0;
    send(8'hB4, 2'b01, ok);
    wait_vld(cyc, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL bp_first_vld: SO_VLD never rose, need 1");
      return;
    end
    DI = 8'h0F; SEL = 2'b00; DI_VLD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (SO !== 8'h5A || SO_LOST !== 1'b0 || SO_VLD !== 1'b1 || DI_RDY !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got SO=%h LOST=%b VLD=%b RDY=%b, need 5a 0 1 0", i, SO, SO_LOST, SO_VLD, DI_RDY);
      end
    end
    SO_RDY = 1'b1;
    @(posedge CLK);
    #1 SO_RDY = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (SO_VLD !== 1'b0 || DI_RDY !== 1'b1 || SO !== 8'h5A) begin
      n_err++;
      $display("FAIL bp_no_bypass: got VLD=%b RDY=%b SO=%h, need 0 1 5a", SO_VLD, DI_RDY, SO);
    end
    @(posedge CLK);
    #1 DI_VLD = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (SO_VLD !== 1'b1 || SO !== 8'h0F || SO_LOST !== 1'b0) begin
      n_err++;
      $display("FAIL bp_next_word: got VLD=%b SO=%h LOST=%b, need 1 0f 0", SO_VLD, SO, SO_LOST);
    end
    SO_RDY = 1'b1;
    @(negedge CLK);
    SO_RDY = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int cyc;
    bit ok;
    SO_RDY = 1'b0;
    send(8'hB5, 2'b10, ok);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({SO, SO_LOST, SO_VLD, DI_RDY} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_mid: got SO=%h LOST=%b VLD=%b RDY=%b, need 00 0 0 1", SO, SO_LOST, SO_VLD, DI_RDY);
    end
    RST = 1'b0;
    SO_RDY = 1'b1;
    send(8'h04, 2'b10, ok);
    wait_vld(cyc, ok);
    n_cmp++;
    if (!ok || cyc != 3 || SO !== 8'h01 || SO_LOST !== 1'b0) begin
      n_err++;
      $display("FAIL rst_after: got lat=%0d SO=%h LOST=%b, need 3 01 0", cyc, SO, SO_LOST);
    end
    @(negedge CLK);
    SO_RDY = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d;
    logic [SELW-1:0]  s;
    int cyc, hold;
    bit ok;
    for (int n = 0; n < 40; n++) begin
      d = WIDTH'($urandom);
      s = SELW'($urandom);
      hold = $urandom_range(0, 3);
      SO_RDY = 1'b0;
      send(d, s, ok);
      wait_vld(cyc, ok);
      n_cmp++;
      if (!ok || cyc != ref_amt(s) + 1 || SO !== ref_so(d, s) || SO_LOST !== ref_lost(d, s)) begin
        n_err++;
        $display("FAIL rnd%0d DI=%h SEL=%b: got lat=%0d SO=%h LOST=%b, need lat=%0d SO=%h LOST=%b",
                 n, d, s, cyc, SO, SO_LOST, ref_amt(s) + 1, ref_so(d, s), ref_lost(d, s));
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge CLK);
        n_cmp++;
        if (SO_VLD !== 1'b1 || SO !== ref_so(d, s)) begin
          n_err++;
          $display("FAIL rnd%0d_hold: got VLD=%b SO=%h, need 1 %h", n, SO_VLD, SO, ref_so(d, s));
        end
      end
      SO_RDY = 1'b1;
      @(negedge CLK);
      SO_RDY = 1'b0;
    end
  endtask

  initial begin
    RST = 1'b1; DI = '0; SEL = '0; DI_VLD = 1'b0; SO_RDY = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
